video_timing_gen: RTL and testbench

//  Raster timing source for the HDMI pattern path. Generates pixel coordinates x/y, data-enable,

---
 rtl/video_timing_gen_pkg.sv | 39 +++
 rtl/video_timing_gen_axis.sv | 55 +++++
 rtl/video_timing_gen.sv | 133 +++++++++++++
 tb/tb_video_timing_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared types for the raster timing generator: region codes and standard mode presets.
package video_timing_gen_pkg;

  typedef enum logic [1:0] {
    RGN_ACTIVE,
    RGN_FP,
    RGN_SYNC,
    RGN_BP
  } region_e;

  typedef struct packed {
    logic [12:0] h_active;
    logic [12:0] h_fp;
    logic [12:0] h_sync;
    logic [12:0] h_bp;
    logic [12:0] v_active;
    logic [12:0] v_fp;
    logic [12:0] v_sync;
    logic [12:0] v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } timing_preset_t;

  localparam timing_preset_t PRESET_640X480_60 = '{
    h_active: 13'd640,  h_fp: 13'd16, h_sync: 13'd96, h_bp: 13'd48,
    v_active: 13'd480,  v_fp: 13'd10, v_sync: 13'd2,  v_bp: 13'd33,
    hs_pol: 1'b0, vs_pol: 1'b0};

  localparam timing_preset_t PRESET_1280X720_60 = '{
    h_active: 13'd1280, h_fp: 13'd110, h_sync: 13'd40, h_bp: 13'd220,
    v_active: 13'd720,  v_fp: 13'd5,   v_sync: 13'd5,  v_bp: 13'd20,
    hs_pol: 1'b1, vs_pol: 1'b1};

  localparam timing_preset_t PRESET_1920X1080_60 = '{
    h_active: 13'd1920, h_fp: 13'd88, h_sync: 13'd44, h_bp: 13'd148,
    v_active: 13'd1080, v_fp: 13'd4,  v_sync: 13'd5,  v_bp: 13'd36,
    hs_pol: 1'b1, vs_pol: 1'b1};

endpackage

// File: rtl/video_timing_gen_axis.sv
// One raster axis: wrapping position counter plus active/fp/sync/bp region decode.
module timing_axis_counter
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned IN_BITS = 13
) (
  input  logic               i_clk,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [IN_BITS-1:0] i_active,
  input  logic [IN_BITS-1:0] i_fp,
  input  logic [IN_BITS-1:0] i_sync,
  input  logic [IN_BITS-1:0] i_bp,
  output logic [IN_BITS:0]   o_cnt,
  output logic               o_last,
  output region_e            o_region
);

  localparam int unsigned CW = IN_BITS + 1;

  logic [CW-1:0] w_fp_start;
  logic [CW-1:0] w_sync_start;
  logic [CW-1:0] w_bp_start;
  logic [CW-1:0] w_total;
  logic [CW-1:0] r_cnt;

  assign w_fp_start   = CW'(i_active);
  assign w_sync_start = w_fp_start + CW'(i_fp);
  assign w_bp_start   = w_sync_start + CW'(i_sync);
  assign w_total      = w_bp_start + CW'(i_bp);

  assign o_last = (r_cnt == w_total - CW'(1));
  assign o_cnt  = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_last ? '0 : r_cnt + CW'(1);
    end
  end

  // Zero-length porches fall through naturally since their ranges are empty.
  always_comb begin
    o_region = RGN_BP;
    if (r_cnt < w_fp_start) begin
      o_region = RGN_ACTIVE;
    end else if (r_cnt < w_sync_start) begin
      o_region = RGN_FP;
    end else if (r_cnt < w_bp_start) begin
      o_region = RGN_SYNC;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: shadowed runtime config, h/v axis counters and registered video outputs.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned X_BITS = 13,
  parameter int unsigned Y_BITS = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [X_BITS-1:0] h_active,
  input  logic [X_BITS-1:0] h_fp,
  input  logic [X_BITS-1:0] h_sync,
  input  logic [X_BITS-1:0] h_bp,
  input  logic [Y_BITS-1:0] v_active,
  input  logic [Y_BITS-1:0] v_fp,
  input  logic [Y_BITS-1:0] v_sync,
  input  logic [Y_BITS-1:0] v_bp,
  input  logic              hs_pol,
  input  logic              vs_pol,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              line_start,
  output logic              frame_start,
  output logic [X_BITS-1:0] total_active_pix,
  output logic              cfg_err
);

  logic [X_BITS-1:0] r_h_active, r_h_fp, r_h_sync, r_h_bp;
  logic [Y_BITS-1:0] r_v_active, r_v_fp, r_v_sync, r_v_bp;
  logic              r_hs_pol, r_vs_pol;

  logic [X_BITS:0]   w_h_cnt;
  logic [Y_BITS:0]   w_v_cnt;
  logic              w_h_last, w_v_last;
  region_e           w_h_rgn, w_v_rgn;
  logic              w_bad, w_run, w_clr, w_frame_end, w_latch, w_de;

  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;
  logic              r_de, r_hsync, r_vsync, r_line_start, r_frame_start, r_cfg_err;
  logic [X_BITS-1:0] r_tap;

  assign w_bad = (r_h_active == '0) || (r_h_sync == '0) ||
                 (r_v_active == '0) || (r_v_sync == '0);
  assign w_run = !w_bad;
  assign w_clr = !rst_n || w_bad;

  // An invalid config holds the counters, so the frame-end reload is gated to keep
  // cfg_err sticky until the next reset even for degenerate 1x1 totals.
  assign w_frame_end = w_h_last && w_v_last && w_run;
  assign w_latch     = !rst_n || w_frame_end;

  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_h_active <= h_active;
      r_h_fp     <= h_fp;
      r_h_sync   <= h_sync;
      r_h_bp     <= h_bp;
      r_v_active <= v_active;
      r_v_fp     <= v_fp;
      r_v_sync   <= v_sync;
      r_v_bp     <= v_bp;
      r_hs_pol   <= hs_pol;
      r_vs_pol   <= vs_pol;
    end
  end

  timing_axis_counter #(.IN_BITS(X_BITS)) u_h_axis (
    .i_clk    (clk),
    .i_clr    (w_clr),
    .i_en     (1'b1),
    .i_active (r_h_active),
    .i_fp     (r_h_fp),
    .i_sync   (r_h_sync),
    .i_bp     (r_h_bp),
    .o_cnt    (w_h_cnt),
    .o_last   (w_h_last),
    .o_region (w_h_rgn)
  );

  timing_axis_counter #(.IN_BITS(Y_BITS)) u_v_axis (
    .i_clk    (clk),
    .i_clr    (w_clr),
    .i_en     (w_h_last),
    .i_active (r_v_active),
    .i_fp     (r_v_fp),
    .i_sync   (r_v_sync),
    .i_bp     (r_v_bp),
    .o_cnt    (w_v_cnt),
    .o_last   (w_v_last),
    .o_region (w_v_rgn)
  );

  assign w_de = w_run && (w_h_rgn == RGN_ACTIVE) && (w_v_rgn == RGN_ACTIVE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_de          <= 1'b0;
      r_hsync       <= ~hs_pol;
      r_vsync       <= ~vs_pol;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_tap         <= '0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_de          <= w_de;
      r_x           <= w_de ? w_h_cnt[X_BITS-1:0] : '0;
      r_y           <= w_de ? w_v_cnt[Y_BITS-1:0] : '0;
      r_hsync       <= (w_run && (w_h_rgn == RGN_SYNC)) ? r_hs_pol : ~r_hs_pol;
      r_vsync       <= (w_run && (w_v_rgn == RGN_SYNC)) ? r_vs_pol : ~r_vs_pol;
      r_line_start  <= w_run && (w_h_cnt == '0);
      r_frame_start <= w_run && (w_h_cnt == '0) && (w_v_cnt == '0);
      r_tap         <= r_h_active;
      r_cfg_err     <= w_bad;
    end
  end

  assign x                = r_x;
  assign y                = r_y;
  assign de               = r_de;
  assign hsync            = r_hsync;
  assign vsync            = r_vsync;
  assign line_start       = r_line_start;
  assign frame_start      = r_frame_start;
  assign total_active_pix = r_tap;
  assign cfg_err          = r_cfg_err;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: frame-position reference model plus directed raster scenarios.
module tb_video_timing_gen;

  typedef struct packed {
    logic [12:0] ha, hf, hs, hb;
    logic [12:0] va, vf, vs, vb;
    logic        hp, vp;
  } cfg_t;

  typedef struct packed {
    logic        de;
    logic [12:0] x;
    logic [12:0] y;
    logic        hsync;
    logic        vsync;
    logic        ls;
    logic        fs;
    logic [12:0] tap;
    logic        err;
  } outs_t;

  localparam cfg_t T = '{ha: 13'd4, hf: 13'd1, hs: 13'd2, hb: 13'd1,
                         va: 13'd3, vf: 13'd1, vs: 13'd1, vb: 13'd1,
                         hp: 1'b1, vp: 1'b1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  cfg_t        in_cfg = T;
  cfg_t        cfg_cur = T;
  int unsigned pos = 0;
  outs_t       want;
  outs_t       obs;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [12:0] x, y, tap;
  logic        de, hsync, vsync, line_start, frame_start, cfg_err;

  always #5 clk = ~clk;

  video_timing_gen #(.X_BITS(13), .Y_BITS(13)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .h_active         (in_cfg.ha),
    .h_fp             (in_cfg.hf),
    .h_sync           (in_cfg.hs),
    .h_bp             (in_cfg.hb),
    .v_active         (in_cfg.va),
    .v_fp             (in_cfg.vf),
    .v_sync           (in_cfg.vs),
    .v_bp             (in_cfg.vb),
    .hs_pol           (in_cfg.hp),
    .vs_pol           (in_cfg.vp),
    .x                (x),
    .y                (y),
    .de               (de),
    .hsync            (hsync),
    .vsync            (vsync),
    .line_start       (line_start),
    .frame_start      (frame_start),
    .total_active_pix (tap),
    .cfg_err          (cfg_err)
  );

  assign obs = {de, x, y, hsync, vsync, line_start, frame_start, tap, cfg_err};

  function automatic logic is_bad(cfg_t c);
    return (c.ha == 0) || (c.hs == 0) || (c.va == 0) || (c.vs == 0);
  endfunction

  function automatic int unsigned frame_len(cfg_t c);
    int unsigned ht, vt;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    return ht * vt;
  endfunction

  // Expected outputs for linear position pos within a frame of config c.
  function automatic outs_t model_out(cfg_t c, int unsigned pos_i);
    outs_t o;
    int unsigned ht, h, v, hss, vss;
    o = '0;
    o.tap = c.ha;
    if (is_bad(c)) begin
      o.err   = 1'b1;
      o.hsync = ~c.hp;
      o.vsync = ~c.vp;
      return o;
    end
    ht  = c.ha + c.hf + c.hs + c.hb;
    h   = pos_i % ht;
    v   = pos_i / ht;
    hss = c.ha + c.hf;
    vss = c.va + c.vf;
    o.de    = (h < c.ha) && (v < c.va);
    o.x     = o.de ? 13'(h) : 13'd0;
    o.y     = o.de ? 13'(v) : 13'd0;
    o.hsync = (h >= hss && h < hss + c.hs) ? c.hp : ~c.hp;
    o.vsync = (v >= vss && v < vss + c.vs) ? c.vp : ~c.vp;
    o.ls    = (h == 0);
    o.fs    = (pos_i == 0);
    return o;
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.ha = 13'($urandom_range(1, 6));
    c.hf = 13'($urandom_range(0, 2));
    c.hs = 13'($urandom_range(1, 3));
    c.hb = 13'($urandom_range(0, 2));
    c.va = 13'($urandom_range(1, 4));
    c.vf = 13'($urandom_range(0, 2));
    c.vs = 13'($urandom_range(1, 2));
    c.vb = 13'($urandom_range(0, 2));
    c.hp = 1'($urandom_range(0, 1));
    c.vp = 1'($urandom_range(0, 1));
    return c;
  endfunction

  // Advance one clock and compute the expected outputs for that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      want       = '0;
      want.hsync = ~in_cfg.hp;
      want.vsync = ~in_cfg.vp;
      cfg_cur    = in_cfg;
      pos        = 0;
    end else begin
      want = model_out(cfg_cur, pos);
      if (!is_bad(cfg_cur)) begin
        pos++;
        if (pos == frame_len(cfg_cur)) begin
          pos     = 0;
          cfg_cur = in_cfg;
        end
      end
    end
  endtask

  task automatic apply_reset(input cfg_t c);
    in_cfg = c;
    rst_n  = 1'b0;
    tick();
    rst_n  = 1'b1;
  endtask

  task automatic test_reset();
    in_cfg = T;
    rst_n  = 1'b0;
    repeat (2) tick();
    n_total++;
    if (obs !== outs_t'(0)) $display("FAIL reset_state: got %h want %h", obs, outs_t'(0));
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_timing();
    int unsigned hs_n, vs_n, fs_n, ls_n, last_fs;
    hs_n = 0; vs_n = 0; fs_n = 0; ls_n = 0; last_fs = 0;
    for (int unsigned k = 1; k <= 96; k++) begin
      tick();
      n_total++;
      if (obs !== want) $display("FAIL timing_model k=%0d: got %h want %h", k, obs, want);
      else n_pass++;
      if (k <= 5) begin
        n_total++;
        if (de !== (k <= 4) || x !== ((k <= 4) ? 13'(k - 1) : 13'd0) || y !== 13'd0)
          $display("FAIL first_line k=%0d: de=%b x=%0d y=%0d", k, de, x, y);
        else n_pass++;
      end
      if (hsync) hs_n++;
      if (vsync) vs_n++;
      if (line_start) ls_n++;
      if (frame_start) begin fs_n++; last_fs = k; end
    end
    n_total++;
    if (hs_n != 24 || vs_n != 16)
      $display("FAIL sync_counts: hs=%0d vs=%0d want 24 16", hs_n, vs_n);
    else n_pass++;
    n_total++;
    if (fs_n != 2 || ls_n != 12 || last_fs != 49)
      $display("FAIL strobes: fs=%0d ls=%0d last_fs=%0d want 2 12 49", fs_n, ls_n, last_fs);
    else n_pass++;
  endtask

  task automatic test_cfg_change();
    int unsigned gap;
    logic        seen;
    apply_reset(T);
    for (int unsigned k = 0; k < 20; k++) begin
      tick();
      n_total++;
      if (obs !== want) $display("FAIL chg_pre: got %h want %h", obs, want);
      else n_pass++;
    end
    in_cfg.ha = 13'd6;
    seen = 1'b0;
    for (int unsigned k = 0; k < 200 && !seen; k++) begin
      tick();
      n_total++;
      if (obs !== want) $display("FAIL chg_mid: got %h want %h", obs, want);
      else n_pass++;
      seen = frame_start;
    end
    n_total++;
    if (!seen || tap !== 13'd6) $display("FAIL chg_newframe: seen=%b tap=%0d want 6", seen, tap);
    else n_pass++;
    gap = 0;
    seen = 1'b0;
    for (int unsigned k = 1; k < 200 && !seen; k++) begin
      tick();
      n_total++;
      if (obs !== want) $display("FAIL chg_new: got %h want %h", obs, want);
      else n_pass++;
      if (frame_start) begin seen = 1'b1; gap = k; end
    end
    n_total++;
    if (gap != 60) $display("FAIL chg_period: got %0d want 60", gap);
    else n_pass++;
  endtask

  task automatic test_cfg_err();
    cfg_t c;
    int unsigned bad_n;
    c = T;
    c.hs = 13'd0;
    apply_reset(c);
    bad_n = 0;
    for (int unsigned k = 0; k < 40; k++) begin
      tick();
      n_total++;
      if (obs !== want) $display("FAIL err_model: got %h want %h", obs, want);
      else n_pass++;
      if (!cfg_err || de || hsync || vsync || line_start || frame_start) bad_n++;
    end
    n_total++;
    if (bad_n != 0) $display("FAIL err_hold: %0d bad cycles want 0", bad_n);
    else n_pass++;
    apply_reset(T);
    tick();
    n_total++;
    if (cfg_err !== 1'b0 || frame_start !== 1'b1)
      $display("FAIL err_clear: cfg_err=%b fs=%b want 0 1", cfg_err, frame_start);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    cfg_t c;
    c = T;
    c.hp = 1'b0;
    c.vp = 1'b0;
    apply_reset(c);
    for (int unsigned k = 0; k < 100 && pos != 19; k++) begin
      tick();
      n_total++;
      if (obs !== want) $display("FAIL mid_pre: got %h want %h", obs, want);
      else n_pass++;
    end
    n_total++;
    if (pos != 19) $display("FAIL mid_reach: pos=%0d want 19", pos);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_total++;
    if (hsync !== 1'b1 || vsync !== 1'b1 || de || line_start || frame_start)
      $display("FAIL mid_reset: hs=%b vs=%b de=%b ls=%b fs=%b", hsync, vsync, de, line_start, frame_start);
    else n_pass++;
    tick();
    n_total++;
    if (!frame_start || !de || x !== 13'd0 || y !== 13'd0)
      $display("FAIL mid_restart: fs=%b de=%b x=%0d y=%0d", frame_start, de, x, y);
    else n_pass++;
    for (int unsigned k = 0; k < 48; k++) begin
      tick();
      n_total++;
      if (obs !== want) $display("FAIL mid_post: got %h want %h", obs, want);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    cfg_t        c;
    int unsigned n;
    for (int unsigned r = 0; r < 8; r++) begin
      apply_reset(rand_cfg());
      n = 2 * frame_len(cfg_cur) + 5;
      for (int unsigned k = 0; k < n; k++) begin
        if (k == n / 3) begin
          c = rand_cfg();
          if (r == 5) c.hs = 13'd0;
          in_cfg = c;
        end
        tick();
        n_total++;
        if (obs !== want) $display("FAIL rand r=%0d k=%0d: got %h want %h", r, k, obs, want);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_cfg_change();
    test_cfg_err();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
